// File: rtl/fp16_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined fp16 multiplier between NUM_REQ lanes,
// with per-lane credit limits and a tag pipe that routes each product back to its issuer.
module fp16_mult_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int MULT_LATENCY = 4,
  parameter  int MAX_OUT      = 2,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*16-1:0]   req_data_1_i,
  input  logic [NUM_REQ*16-1:0]   req_data_2_i,
  output logic [15:0]             mult_data_1_o,
  output logic [15:0]             mult_data_2_o,
  input  logic [15:0]             mult_data_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [15:0]             rsp_data_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic                    busy_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int DEPTH = MULT_LATENCY + 1;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [DEPTH-1:0]   tag_vld_q;
  logic [ID_W-1:0]    tag_id_q [DEPTH];
  logic [15:0]        mult_data_1_q, mult_data_2_q, rsp_data_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] elig, grant, inc, dec;
  logic               issue;
  logic [ID_W-1:0]    win;
  logic               rsp_pop;
  logic [ID_W-1:0]    rsp_pop_id;

  assign rsp_pop    = tag_vld_q[DEPTH-1];
  assign rsp_pop_id = tag_id_q[DEPTH-1];

  // Search eligible lanes starting at the RR pointer, ascending with wrap.
  always_comb begin
    int idx;
    idx   = 0;
    elig  = '0;
    grant = '0;
    issue = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!issue && elig[idx]) begin
        issue = 1'b1;
        win   = ID_W'(idx);
      end
    end
    if (issue) grant[win] = 1'b1;
    ptr_d = ptr_q;
    if (issue) ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  assign req_ready_o = grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i]   = grant[i];
      dec[i]   = rsp_pop && (int'(rsp_pop_id) == i);
      cnt_d[i] = cnt_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q         <= '0;
      tag_vld_q     <= '0;
      mult_data_1_q <= '0;
      mult_data_2_q <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      busy_q        <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id_q[k] <= '0;
    end else begin
      ptr_q         <= ptr_d;
      // Idle cycles feed 0*0 so the multiplier never computes stale operands.
      mult_data_1_q <= issue ? req_data_1_i[16*win +: 16] : 16'h0000;
      mult_data_2_q <= issue ? req_data_2_i[16*win +: 16] : 16'h0000;
      tag_vld_q     <= {tag_vld_q[DEPTH-2:0], issue};
      tag_id_q[0]   <= win;
      for (int k = 1; k < DEPTH; k++) tag_id_q[k] <= tag_id_q[k-1];
      busy_q        <= |{tag_vld_q[DEPTH-2:0], issue};
      rsp_valid_q   <= '0;
      if (rsp_pop) begin
        rsp_valid_q[rsp_pop_id] <= 1'b1;
        rsp_data_q              <= mult_data_i;
        rsp_id_q                <= rsp_pop_id;
      end
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always @(posedge clk_i) begin
    if (rst_n_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (cnt_q[i] <= CNT_W'(MAX_OUT));
        assert (!(dec[i] && !inc[i] && cnt_q[i] == '0));
      end
    end
  end

  assign mult_data_1_o = mult_data_1_q;
  assign mult_data_2_o = mult_data_2_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_id_o      = rsp_id_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// Bench for fp16_mult_arbiter: directed and random ops, scoreboard of expected
// responses popped by an independent monitor; a pipelined table multiplier stands in for mult_16.
module tb_fp16_mult_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 4;
  localparam int MO  = 2;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*16-1:0]  d1 = '0, d2 = '0;
  logic [15:0]       m1, m2, mult_in, rsp_data;
  logic [NR-1:0]     rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  fp16_mult_arbiter #(.NUM_REQ(NR), .MULT_LATENCY(LAT), .MAX_OUT(MO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_1_i(d1), .req_data_2_i(d2), .mult_data_1_o(m1), .mult_data_2_o(m2),
    .mult_data_i(mult_in), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_id_o(rsp_id), .busy_o(busy));

  always #5 clk = ~clk;

  // Hand-computed fp16 products: va*vb = vp
  logic [15:0] va [10] = '{16'h3C00, 16'h4200, 16'h4000, 16'h3800, 16'h4400,
                           16'h3C00, 16'hC000, 16'h4500, 16'h3400, 16'h0000};
  logic [15:0] vb [10] = '{16'h4000, 16'hC000, 16'h4000, 16'h4000, 16'h4200,
                           16'h3C00, 16'hC000, 16'h4000, 16'h4400, 16'h4000};
  logic [15:0] vp [10] = '{16'h4000, 16'hC600, 16'h4400, 16'h3C00, 16'h4A00,
                           16'h3C00, 16'h4400, 16'h4900, 16'h3C00, 16'h0000};

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h0 && b == 16'h0) return 16'h0;
    for (int i = 0; i < 10; i++) if (a == va[i] && b == vb[i]) return vp[i];
    return 16'hDEAD;
  endfunction

  logic [15:0] mpipe [LAT];
  initial for (int i = 0; i < LAT; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    mpipe[0] <= fmul(m1, m2);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_in = mpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [15:0] exp; int iss; } sb_t;
  typedef struct { int id; int v; int not_before; } op_t;
  typedef struct { int id; int iss; } gr_t;
  sb_t sb [$];
  op_t pend [$];
  gr_t grants [$];
  int infl [NR];
  int nchk = 0, npass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops one expectation per presented response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {28'h0, rsp_valid}, 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("rsp_valid", {28'h0, rsp_valid}, 32'h1 << e.id);
        check("rsp_id", {30'h0, rsp_id}, e.id);
        check("rsp_data", {16'h0, rsp_data}, {16'h0, e.exp});
        check("rsp_latency", cyc, e.iss + LAT + 1);
        infl[e.id]--;
      end
    end
  end

  task automatic drive(input int budget);
    int  k [NR];
    bit  bq [NR];
    int  n;
    n = 0;
    for (int i = 0; i < NR; i++) bq[i] = 0;
    while ((pend.size() > 0 || bq[0] || bq[1] || bq[2] || bq[3]) && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NR; i++) begin
        if (!bq[i]) begin
          for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].id == i) begin
              if (pend[j].not_before <= cyc + 1) begin
                k[i] = pend[j].v;
                bq[i] = 1;
                pend.delete(j);
              end
              break;
            end
          end
        end
        req_valid[i] = bq[i];
        if (bq[i]) begin
          d1[16*i +: 16] = va[k[i]];
          d2[16*i +: 16] = vb[k[i]];
        end
      end
      #1;
      check("ready_onehot0", {31'h0, $onehot0(req_ready)}, 1);
      check("ready_implies_valid", {28'h0, req_ready & ~req_valid}, 0);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && bq[i]) begin
          sb.push_back('{id: i, exp: vp[k[i]], iss: cyc + 1});
          grants.push_back('{id: i, iss: cyc + 1});
          infl[i]++;
          check("credit_limit", {31'h0, infl[i] <= MO}, 1);
          bq[i] = 0;
        end
      end
    end
    if (n >= budget) check("drive_timeout", pend.size(), 0);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drain"}, sb.size(), 0);
    check({name, "_idle_busy"}, {31'h0, busy}, 0);
  endtask

  task automatic reset_dut(input bit do_check);
    @(negedge clk);
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    if (do_check) begin
      check("rst_rsp_valid", {28'h0, rsp_valid}, 0);
      check("rst_rsp_data", {16'h0, rsp_data}, 0);
      check("rst_rsp_id", {30'h0, rsp_id}, 0);
      check("rst_mult_1", {16'h0, m1}, 0);
      check("rst_mult_2", {16'h0, m2}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_ready", {28'h0, req_ready}, 0);
    end
    sb.delete();
    for (int i = 0; i < NR; i++) infl[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int g0;
    for (int i = 0; i < NR; i++) infl[i] = 0;
    #1 rst_n = 1'b0;
    reset_dut(1);

    // Single op on req0: 1.0 * 2.0
    pend.push_back('{id: 0, v: 0, not_before: 0});
    drive(50);
    drain("single");

    // All four requesters streaming: strict 0,1,2,3 rotation, one per cycle
    reset_dut(0);
    grants.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NR; i++) pend.push_back('{id: i, v: (r * 4 + i) % 10, not_before: 0});
    drive(200);
    drain("rr");
    check("rr_count", grants.size(), 12);
    for (int j = 0; j < grants.size(); j++) begin
      check("rr_order", grants[j].id, j % NR);
      check("rr_back_to_back", grants[j].iss, grants[0].iss + j);
    end

    // Req2 alone: credit limit stalls until the first response
    grants.delete();
    for (int j = 0; j < 4; j++) pend.push_back('{id: 2, v: j + 2, not_before: 0});
    drive(200);
    drain("credit");
    g0 = grants[0].iss;
    check("credit_issue1", grants[1].iss, g0 + 1);
    check("credit_issue2", grants[2].iss, g0 + LAT + 2);
    check("credit_issue3", grants[3].iss, g0 + LAT + 3);

    // Req1: issue on the same edge as its previous response, credit count unchanged
    grants.delete();
    pend.push_back('{id: 1, v: 4, not_before: 0});
    drive(50);
    g0 = grants[0].iss;
    pend.push_back('{id: 1, v: 1, not_before: g0 + LAT + 1});
    pend.push_back('{id: 1, v: 2, not_before: 0});
    drive(50);
    drain("same_edge");
    check("same_edge_issue", grants[1].iss, g0 + LAT + 1);
    check("same_edge_next", grants[2].iss, g0 + LAT + 2);

    // Reset with three ops in flight
    grants.delete();
    for (int i = 0; i < 3; i++) pend.push_back('{id: i, v: i + 5, not_before: 0});
    drive(50);
    reset_dut(1);
    repeat (10) @(negedge clk);
    check("post_rst_busy", {31'h0, busy}, 0);
    grants.delete();
    pend.push_back('{id: 3, v: 7, not_before: 0});
    pend.push_back('{id: 0, v: 8, not_before: 0});
    drive(50);
    drain("post_rst");
    check("post_rst_first_grant", grants[0].id, 0);

    // Random mix across all requesters
    for (int j = 0; j < 40; j++)
      pend.push_back('{id: $urandom_range(0, NR - 1), v: $urandom_range(0, 9), not_before: 0});
    drive(600);
    drain("random");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
